alu_seq_pipe: RTL and testbench
===============================

Name: alu_seq_pipe

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU macros: WIDTH-bit operands, opcode-selected operation, flag outputs.
- Valid/ready handshake on input and output.
- Single-cycle ops complete with 1-cycle latency; unsigned multiply runs as an iterative shift-add FSM.
- Sits between operand/opcode sequencer and result writeback in the datapath benchmarks.

Parameters:
- WIDTH, 4, operand/result width (>=2).
- MUL_EN, 1, 1 = opcode 0xA performs multiply; 0 = opcode 0xA treated as reserved.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  block can accept an operation this cycle
- op  input  4  opcode
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (ADD) / borrow-in (SUB)
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  result (low half for MUL)
- result_hi  output  WIDTH  high half of MUL product; 0 for other ops
- flag_c  output  1  carry/borrow/shifted-out bit
- flag_z  output  1  result zero
- flag_n  output  1  result MSB
- flag_v  output  1  signed overflow
- flag_err  output  1  reserved opcode
- busy  output  1  multiply in progress

Behaviour:
- Reset: state=IDLE, out_valid=0, in_ready=1 on the cycle after reset deasserts. result, result_hi and all flags=0, busy=0.
- Reset mid-multiply or while holding a result: the operation and result are discarded; no out_valid pulse.
- Accept = in_valid & in_ready.
- in_ready = (state==IDLE) | (state==HOLD & out_ready).
- in_ready is 0 in MUL and in HOLD without out_ready.
- States:
  - IDLE: on accept of a non-MUL op, register result and flags, go to HOLD (out_valid=1 next cycle, latency 1). On accept of MUL, load multiplicand/multiplier, clear accumulator, count=WIDTH, go to MUL.
  - MUL: one shift-add step per cycle. busy=1. After WIDTH steps, register the product and go to HOLD. Total latency WIDTH+1 cycles from accept to out_valid.
  - HOLD: out_valid=1. Outputs stable until out_ready.
    - out_ready without accept: go to IDLE.
    - out_ready with simultaneous accept of a non-MUL op: the new result is valid next cycle, back-to-back, state stays HOLD.
    - Simultaneous accept of MUL: go to MUL.
- Operand capture: op, a, b and cin are sampled only at accept. Input changes while busy are ignored.
- Opcodes (W=WIDTH, all arithmetic mod 2^W):
  - 0 ADD: {c,r}=a+b+cin. V = sign(a)==sign(b) & sign(r)!=sign(a).
  - 1 SUB: r=a-b-cin. C=1 on borrow. V = sign(a)!=sign(b) & sign(r)!=sign(a).
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOR
  - 6 SHL1: r=a<<1, C=a[W-1].
  - 7 SHR1 (logical): C=a[0].
  - 8 CMP: flags as SUB with cin=0; result=a (unchanged).
  - 9 PASSB: r=b.
  - A MUL (unsigned): {result_hi,result}=a*b. Z over the full 2W product. N=result_hi[W-1]. C=(result_hi!=0). V=0.
  - B-F reserved: result=0, err=1, Z=1, other flags 0, latency 1.
- Flags not listed for an op are 0. C for logic ops is 0. N=r[W-1] except MUL.
- result_hi=0 for every non-MUL op.

Test Plan:
- W=4, ADD a=7,b=1,cin=0, out_ready=1 -> 1 cycle later result=8, C=0, Z=0, N=1, V=1; in_ready=1 throughout.
- W=4, SUB a=3,b=5,cin=0 -> result=0xE, C=1, N=1, V=0. Then CMP a=5,b=5 -> result=5, Z=1, C=0.
- W=4, MUL a=0xF,b=0xF, out_ready=1 -> busy=1 and in_ready=0 for 4 cycles. out_valid at cycle 5 with result_hi=0xE, result=0x1, C=1, Z=0.
- Backpressure: ADD 1+1 with out_ready=0 for 3 cycles -> result=2 held, in_ready=0. Then out_ready=1 with in_valid=1 XOR a=0xA,b=0xA -> next cycle result=0, Z=1, no gap.
- Reserved op 0xC, a=0xF -> result=0, flag_err=1, Z=1. Same op with MUL_EN=0 on 0xA -> flag_err=1.
- Assert rst for 1 cycle at MUL step 2 -> out_valid never rises for that op. Next cycle in_ready=1, all outputs 0. A fresh ADD 2+3 gives result=5.

Source files
------------

// File: rtl/alu_seq_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pipe
//  Purpose  : Registered WIDTH-bit ALU with valid/ready handshakes on both
//             sides. Single-cycle ops produce a result one cycle after accept;
//             unsigned multiply (opcode 0xA, when MUL_EN=1) runs as an
//             iterative shift-add over WIDTH cycles.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_valid/in_ready   - operation handshake (op, a, b, cin)
//             out_valid/out_ready - result handshake
//             result, result_hi   - result (low/high product half for MUL)
//             flag_c/z/n/v/err    - carry, zero, negative, overflow, reserved
//             busy                - multiply in progress
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_pipe #(
  parameter int WIDTH  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d, err_q, err_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               is_mul;
  logic               cin_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [WIDTH-1:0]   alu_r, zn_src;
  logic               alu_c, alu_v, alu_err;
  logic [2*WIDTH-1:0] acc_step;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q == S_MUL);
  assign is_mul    = MUL_EN && (op == 4'hA);

  // CMP is a subtract that ignores the borrow-in.
  assign cin_eff  = (op == 4'h8) ? 1'b0 : cin;
  assign sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign dif      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_eff};
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle ALU evaluated on the live inputs; only consumed at accept.
  always_comb begin
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      4'h0: begin
        alu_r = sum[MSB:0];
        alu_c = sum[WIDTH];
        alu_v = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
      end
      4'h1, 4'h8: begin
        alu_r = (op == 4'h8) ? a : dif[MSB:0];
        alu_c = dif[WIDTH];
        alu_v = (a[MSB] != b[MSB]) & (dif[MSB] != a[MSB]);
      end
      4'h2: alu_r = a & b;
      4'h3: alu_r = a | b;
      4'h4: alu_r = a ^ b;
      4'h5: alu_r = ~(a | b);
      4'h6: begin
        alu_r = {a[MSB-1:0], 1'b0};
        alu_c = a[MSB];
      end
      4'h7: begin
        alu_r = {1'b0, a[MSB:1]};
        alu_c = a[0];
      end
      4'h9: alu_r = b;
      // 0xA lands here when multiply is disabled, making it reserved.
      default: alu_err = 1'b1;
    endcase
    // CMP reports Z/N of the difference while passing A through.
    zn_src = (op == 4'h8) ? dif[MSB:0] : alu_r;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && out_ready) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = S_MUL;
          end else begin
            result_d = alu_r;
            hi_d     = '0;
            c_d      = alu_c;
            z_d      = (zn_src == '0);
            n_d      = zn_src[MSB];
            v_d      = alu_v;
            err_d    = alu_err;
            state_d  = S_HOLD;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        // The last partial product is folded straight into the outputs.
        if (cnt_q == CNT_W'(1)) begin
          result_d = acc_step[MSB:0];
          hi_d     = acc_step[2*WIDTH-1:WIDTH];
          c_d      = (acc_step[2*WIDTH-1:WIDTH] != '0);
          z_d      = (acc_step == '0);
          n_d      = acc_step[2*WIDTH-1];
          v_d      = 1'b0;
          err_d    = 1'b0;
          state_d  = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result    = result_q;
  assign result_hi = hi_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;
  assign flag_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_pipe
//  Purpose  : Self-checking bench for alu_seq_pipe (WIDTH=4). One instance
//             with multiply enabled, one with it disabled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_pipe;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, cin, busy;
  logic [3:0]   op;
  logic [W-1:0] a, b, result, result_hi;
  logic         flag_c, flag_z, flag_n, flag_v, flag_err;

  logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_cin, n_busy;
  logic [3:0]   n_op;
  logic [W-1:0] n_a, n_b, n_result, n_result_hi;
  logic         n_flag_c, n_flag_z, n_flag_n, n_flag_v, n_flag_err;

  alu_seq_pipe #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .flag_c(flag_c), .flag_z(flag_z),
    .flag_n(flag_n), .flag_v(flag_v), .flag_err(flag_err), .busy(busy)
  );

  alu_seq_pipe #(.WIDTH(W), .MUL_EN(1'b0)) u_dut_nomul (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .op(n_op),
    .a(n_a), .b(n_b), .cin(n_cin), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result(n_result), .result_hi(n_result_hi), .flag_c(n_flag_c), .flag_z(n_flag_z),
    .flag_n(n_flag_n), .flag_v(n_flag_v), .flag_err(n_flag_err), .busy(n_busy)
  );

  // {result, result_hi, C, Z, N, V, ERR} and {out_valid, in_ready, busy}
  logic [2*W+4:0] obs, n_obs;
  logic [2:0]     st;
  assign obs   = {result, result_hi, flag_c, flag_z, flag_n, flag_v, flag_err};
  assign n_obs = {n_result, n_result_hi, n_flag_c, n_flag_z, n_flag_n, n_flag_v, n_flag_err};
  assign st    = {out_valid, in_ready, busy};

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic logic [2*W+4:0] model(input int o, input int x, input int y,
                                           input int ci, input bit mul_en);
    int r, hi, s, p, sx, sy;
    bit c, z, n, v, err;
    sx = (x >= M/2) ? x - M : x;
    sy = (y >= M/2) ? y - M : y;
    r = 0; hi = 0; s = 0; p = 0;
    c = 1'b0; v = 1'b0; err = 1'b0;
    case (o)
      0: begin s = x + y + ci; r = s % M; c = (s >= M);
               v = (sx + sy + ci > M/2 - 1) || (sx + sy + ci < -M/2); end
      1: begin s = x - y - ci; r = (s + 2*M) % M; c = (s < 0);
               v = (sx - sy - ci > M/2 - 1) || (sx - sy - ci < -M/2); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = (M - 1) - (x | y);
      6: begin r = (x * 2) % M; c = (x >= M/2); end
      7: begin r = x / 2; c = (x % 2 == 1); end
      8: begin s = x - y; r = x; c = (s < 0);
               v = (sx - sy > M/2 - 1) || (sx - sy < -M/2); end
      9: r = y;
      10: if (mul_en) begin p = x * y; r = p % M; hi = p / M; c = (hi != 0); end
          else err = 1'b1;
      default: err = 1'b1;
    endcase
    if (o == 8) begin
      z = (s == 0); n = (((s + M) % M) >= M/2);
    end else if (o == 10 && mul_en) begin
      z = (p == 0); n = (hi >= M/2);
    end else begin
      z = (r == 0); n = (r >= M/2);
    end
    return {r[W-1:0], hi[W-1:0], c, z, n, v, err};
  endfunction

  // Presents one operation at the current negedge; returns one cycle later.
  // Inputs are scrambled afterwards so late capture would be visible.
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci);
    in_valid = 1'b1; op = o; a = x; b = y; cin = ci;
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    n_in_valid = 1'b0; n_out_ready = 1'b1; n_op = '0; n_a = '0; n_b = '0; n_cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    checks++;
    if (st !== 3'b010) begin errors++; $display("FAIL reset_status got=%b exp=010", st); end
    checks++;
    if ({n_obs, n_out_valid, n_busy} !== '0) begin
      errors++; $display("FAIL reset_nomul got=%h exp=0", {n_obs, n_out_valid, n_busy});
    end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready_pre got=%b exp=1", in_ready); end
    send(4'h0, 4'h7, 4'h1, 1'b0);
    checks++;
    if (st !== 3'b110) begin errors++; $display("FAIL add_status got=%b exp=110", st); end
    checks++;
    if (obs !== {4'h8, 4'h0, 5'b00110}) begin
      errors++; $display("FAIL add_result got=%h exp=%h", obs, {4'h8, 4'h0, 5'b00110});
    end
  endtask

  task automatic test_sub_cmp();
    send(4'h1, 4'h3, 4'h5, 1'b0);
    checks++;
    if (obs !== {4'hE, 4'h0, 5'b10100} || st !== 3'b110) begin
      errors++; $display("FAIL sub got=%h/%b exp=%h/110", obs, st, {4'hE, 4'h0, 5'b10100});
    end
    send(4'h8, 4'h5, 4'h5, 1'b1);
    checks++;
    if (obs !== {4'h5, 4'h0, 5'b01000} || st !== 3'b110) begin
      errors++; $display("FAIL cmp got=%h/%b exp=%h/110", obs, st, {4'h5, 4'h0, 5'b01000});
    end
    @(negedge clk);
    checks++;
    if (st !== 3'b010) begin errors++; $display("FAIL drain_idle got=%b exp=010", st); end
  endtask

  task automatic test_mul();
    send(4'hA, 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st !== 3'b001) begin errors++; $display("FAIL mul_busy cyc=%0d got=%b exp=001", i, st); end
      @(negedge clk);
    end
    checks++;
    if (st !== 3'b110) begin errors++; $display("FAIL mul_done got=%b exp=110", st); end
    checks++;
    if (obs !== {4'h1, 4'hE, 5'b10100}) begin
      errors++; $display("FAIL mul_result got=%h exp=%h", obs, {4'h1, 4'hE, 5'b10100});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'h0, 4'h1, 4'h1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st !== 3'b100 || obs !== {4'h2, 4'h0, 5'b00000}) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=%h/100", i, obs, st,
                           {4'h2, 4'h0, 5'b00000});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (st !== 3'b110) begin errors++; $display("FAIL bp_release got=%b exp=110", st); end
    send(4'h4, 4'hA, 4'hA, 1'b0);
    checks++;
    if (st !== 3'b110 || obs !== {4'h0, 4'h0, 5'b01000}) begin
      errors++; $display("FAIL back_to_back got=%h/%b exp=%h/110", obs, st, {4'h0, 4'h0, 5'b01000});
    end
    @(negedge clk);
  endtask

  task automatic test_reserved();
    for (int o = 11; o < 16; o++) begin
      send(4'(o), (o == 12) ? 4'hF : 4'($urandom), 4'($urandom), 1'($urandom));
      checks++;
      if (st !== 3'b110 || obs !== {4'h0, 4'h0, 5'b01001}) begin
        errors++; $display("FAIL reserved op=%0h got=%h/%b exp=%h/110", o, obs, st,
                           {4'h0, 4'h0, 5'b01001});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mul_disabled();
    n_in_valid = 1'b1; n_op = 4'hA; n_a = 4'h3; n_b = 4'h5; n_cin = 1'b0;
    @(negedge clk);
    n_in_valid = 1'b0;
    checks++;
    if (n_out_valid !== 1'b1 || n_busy !== 1'b0 || n_obs !== {4'h0, 4'h0, 5'b01001}) begin
      errors++; $display("FAIL nomul_op_a got=%h v=%b busy=%b exp=%h", n_obs, n_out_valid,
                         n_busy, {4'h0, 4'h0, 5'b01001});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    send(4'hA, 4'h3, 4'h3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (st !== 3'b010 || obs !== '0) begin
      errors++; $display("FAIL rst_mid_mul got=%h/%b exp=0/010", obs, st);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_valid cyc=%0d got=1 exp=0", i); end
      @(negedge clk);
    end
    send(4'h0, 4'h2, 4'h3, 1'b0);
    checks++;
    if (obs !== {4'h5, 4'h0, 5'b00000}) begin
      errors++; $display("FAIL post_rst_add got=%h exp=%h", obs, {4'h5, 4'h0, 5'b00000});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2*W+4:0] exp_q[$];
    logic [2*W+4:0] e;
    for (int cyc = 0; cyc < 500; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      #1;
      checks++;
      if (in_ready !== (!busy && (!out_valid || out_ready))) begin
        errors++; $display("FAIL rand_in_ready cyc=%0d got=%b st=%b", cyc, in_ready, st);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious cyc=%0d got=%h exp=none", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL rand_result cyc=%0d got=%h exp=%h", cyc, obs, e); end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(op), int'(a), int'(b), int'(cin), 1'b1));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
      #1;
      if (out_valid) begin
        checks++;
        e = exp_q.pop_front();
        if (obs !== e) begin errors++; $display("FAIL rand_drain got=%h exp=%h", obs, e); end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_timeout pending=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_backpressure();
    test_reserved();
    test_mul_disabled();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
